// File: rtl/mp64_dma_bridge.sv
// mp64_dma_bridge
//   Bridges a byte-wide DMA master (disk controller) onto a 64-bit memory bus.
//   Sequential byte writes are gathered into a one-word write buffer and sent
//   out as a single masked word write. Byte reads are served from a one-word
//   read buffer that is refilled by whole-word fetches.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   dma_req/addr/wdata/wen          byte request from the DMA master
//   dma_rdata, dma_ack              read byte and one-cycle completion pulse
//   flush                           request write-out of any partial word
//   idle                            nothing buffered, nothing in flight
//   mem_req/addr/wen/wdata/be       word request towards the bus arbiter
//   mem_rdata, mem_ack              word read data and completion pulse
module mp64_dma_bridge #(
   parameter int unsigned FLUSH_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dma_req,
   input  logic [63:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   input  logic        dma_wen,
   output logic [7:0]  dma_rdata,
   output logic        dma_ack,
   input  logic        flush,
   output logic        idle,
   output logic        mem_req,
   output logic [63:0] mem_addr,
   output logic        mem_wen,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_be,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int CW = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(FLUSH_TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WFLUSH, ST_RFETCH, ST_ACK} state_t;

   state_t        state_q, state_d;
   logic [60:0]   wbuf_word_q, wbuf_word_d;
   logic [63:0]   wbuf_data_q, wbuf_data_d;
   logic [7:0]    wbuf_mask_q, wbuf_mask_d;
   logic [60:0]   rbuf_word_q, rbuf_word_d;
   logic [63:0]   rbuf_data_q, rbuf_data_d;
   logic          rbuf_valid_q, rbuf_valid_d;
   logic [63:0]   cur_addr_q, cur_addr_d;
   logic [7:0]    cur_wdata_q, cur_wdata_d;
   logic          cur_wen_q, cur_wen_d;
   logic          pend_q, pend_d;
   logic          flush_pend_q, flush_pend_d;
   logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]    dma_rdata_q, dma_rdata_d;
   logic          dma_ack_q, dma_ack_d;
   logic          idle_q, idle_d;
   logic          mem_req_q, mem_req_d;
   logic [63:0]   mem_addr_q, mem_addr_d;
   logic          mem_wen_q, mem_wen_d;
   logic [63:0]   mem_wdata_q, mem_wdata_d;
   logic [7:0]    mem_be_q, mem_be_d;

   logic          req_any;
   logic [63:0]   eff_addr;
   logic [7:0]    eff_wdata;
   logic          eff_wen;
   logic [60:0]   eff_word;
   logic [5:0]    eff_shift;
   logic [5:0]    cur_shift;
   logic          start_wf;
   logic          start_rf;
   logic          flush_clr;

   // A request deferred behind a write flush is replayed from the captured
   // copy before any new master request is looked at.
   always_comb begin
      req_any   = pend_q | dma_req;
      eff_addr  = pend_q ? cur_addr_q  : dma_addr;
      eff_wdata = pend_q ? cur_wdata_q : dma_wdata;
      eff_wen   = pend_q ? cur_wen_q   : dma_wen;
      eff_word  = eff_addr[63:3];
      eff_shift = {eff_addr[2:0], 3'b000};
      cur_shift = {cur_addr_q[2:0], 3'b000};
   end

   // Next-state logic. In IDLE a request beats a latched flush, which beats
   // the inactivity timeout; a latched flush survives a cycle lost to a request.
   always_comb begin
      state_d      = state_q;
      wbuf_word_d  = wbuf_word_q;
      wbuf_data_d  = wbuf_data_q;
      wbuf_mask_d  = wbuf_mask_q;
      rbuf_word_d  = rbuf_word_q;
      rbuf_data_d  = rbuf_data_q;
      rbuf_valid_d = rbuf_valid_q;
      cur_addr_d   = cur_addr_q;
      cur_wdata_d  = cur_wdata_q;
      cur_wen_d    = cur_wen_q;
      pend_d       = pend_q;
      tmo_cnt_d    = tmo_cnt_q;
      dma_rdata_d  = dma_rdata_q;
      dma_ack_d    = 1'b0;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      mem_wen_d    = mem_wen_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      start_wf     = 1'b0;
      start_rf     = 1'b0;
      flush_clr    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               tmo_cnt_d   = '0;
               cur_addr_d  = eff_addr;
               cur_wdata_d = eff_wdata;
               cur_wen_d   = eff_wen;
               pend_d      = 1'b0;
               if (eff_wen) begin
                  if (wbuf_mask_q != 8'h00 && eff_word != wbuf_word_q) begin
                     pend_d   = 1'b1;
                     start_wf = 1'b1;
                  end else begin
                     wbuf_word_d                   = eff_word;
                     wbuf_data_d[eff_shift +: 8]   = eff_wdata;
                     wbuf_mask_d[eff_addr[2:0]]    = 1'b1;
                     if (rbuf_valid_q && rbuf_word_q == eff_word) begin
                        rbuf_data_d[eff_shift +: 8] = eff_wdata;
                     end
                     state_d = ST_ACK;
                  end
               end else begin
                  if (wbuf_mask_q != 8'h00 && eff_word == wbuf_word_q) begin
                     pend_d   = 1'b1;
                     start_wf = 1'b1;
                  end else if (rbuf_valid_q && rbuf_word_q == eff_word) begin
                     state_d = ST_ACK;
                  end else begin
                     start_rf = 1'b1;
                  end
               end
            end else if (flush_pend_q) begin
               flush_clr = 1'b1;
               if (wbuf_mask_q != 8'h00) begin
                  start_wf = 1'b1;
               end
            end else if (wbuf_mask_q != 8'h00) begin
               if (tmo_cnt_q == TMO_LAST) begin
                  start_wf = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
               end
            end
         end
         ST_WFLUSH: begin
            if (mem_ack) begin
               mem_req_d   = 1'b0;
               wbuf_mask_d = 8'h00;
               state_d     = ST_IDLE;
            end
         end
         ST_RFETCH: begin
            if (mem_ack) begin
               mem_req_d    = 1'b0;
               rbuf_word_d  = cur_addr_q[63:3];
               rbuf_data_d  = mem_rdata;
               rbuf_valid_d = 1'b1;
               state_d      = ST_ACK;
            end
         end
         default: begin
            dma_ack_d = 1'b1;
            if (!cur_wen_q) begin
               dma_rdata_d = rbuf_data_q[cur_shift +: 8];
            end
            if (wbuf_mask_q == 8'hFF) begin
               start_wf = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase

      if (start_wf) begin
         state_d     = ST_WFLUSH;
         tmo_cnt_d   = '0;
         mem_req_d   = 1'b1;
         mem_wen_d   = 1'b1;
         mem_addr_d  = {wbuf_word_q, 3'b000};
         mem_wdata_d = wbuf_data_q;
         mem_be_d    = wbuf_mask_q;
      end
      if (start_rf) begin
         state_d    = ST_RFETCH;
         mem_req_d  = 1'b1;
         mem_wen_d  = 1'b0;
         mem_addr_d = {eff_word, 3'b000};
         mem_be_d   = 8'hFF;
      end

      flush_pend_d = flush | (flush_pend_q & ~flush_clr);
      idle_d = (state_d == ST_IDLE) && (wbuf_mask_d == 8'h00) && !flush_pend_d && !pend_d;
   end

   // All state and every output is registered; reset discards buffered data
   // and drops any bus request immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         wbuf_word_q  <= '0;
         wbuf_data_q  <= '0;
         wbuf_mask_q  <= '0;
         rbuf_word_q  <= '0;
         rbuf_data_q  <= '0;
         rbuf_valid_q <= 1'b0;
         cur_addr_q   <= '0;
         cur_wdata_q  <= '0;
         cur_wen_q    <= 1'b0;
         pend_q       <= 1'b0;
         flush_pend_q <= 1'b0;
         tmo_cnt_q    <= '0;
         dma_rdata_q  <= '0;
         dma_ack_q    <= 1'b0;
         idle_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_wen_q    <= 1'b0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
      end else begin
         state_q      <= state_d;
         wbuf_word_q  <= wbuf_word_d;
         wbuf_data_q  <= wbuf_data_d;
         wbuf_mask_q  <= wbuf_mask_d;
         rbuf_word_q  <= rbuf_word_d;
         rbuf_data_q  <= rbuf_data_d;
         rbuf_valid_q <= rbuf_valid_d;
         cur_addr_q   <= cur_addr_d;
         cur_wdata_q  <= cur_wdata_d;
         cur_wen_q    <= cur_wen_d;
         pend_q       <= pend_d;
         flush_pend_q <= flush_pend_d;
         tmo_cnt_q    <= tmo_cnt_d;
         dma_rdata_q  <= dma_rdata_d;
         dma_ack_q    <= dma_ack_d;
         idle_q       <= idle_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         mem_wen_q    <= mem_wen_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
      end
   end

   assign dma_rdata = dma_rdata_q;
   assign dma_ack   = dma_ack_q;
   assign idle      = idle_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wen   = mem_wen_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mp64_dma_bridge.sv
// tb_mp64_dma_bridge
//   Bench for mp64_dma_bridge. A bus-side memory responder with random latency
//   stands in for the arbiter. A byte-level golden memory records what the
//   DMA master has written; reads must return the golden byte and, once
//   everything is flushed, the bus-side memory must equal the golden image.
module tb_mp64_dma_bridge;

   logic        clk;
   logic        rst_n;
   logic        dma_req;
   logic [63:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_wen;
   logic [7:0]  dma_rdata;
   logic        dma_ack;
   logic        flush;
   logic        idle;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;
   logic [63:0] mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;
   int memWrites = 0;
   int memReads = 0;
   int ackCount = 0;
   int ackWrites = 0;
   int respDelay = 0;
   logic        holdAck = 1'b0;
   logic [63:0] lastWAddr = '0;
   logic [7:0]  lastWBe = '0;
   logic [63:0] lastWData = '0;

   logic [63:0] memArr [logic [60:0]];
   logic [63:0] gold   [logic [60:0]];

   mp64_dma_bridge #(.FLUSH_TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wen(dma_wen),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack), .flush(flush), .idle(idle),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Contents of a word nobody has written yet.
   function automatic logic [63:0] initWord(input logic [60:0] w);
      return {w[28:0], 3'b101, ~w[31:0]};
   endfunction

   function automatic logic [63:0] memGet(input logic [60:0] w);
      return memArr.exists(w) ? memArr[w] : initWord(w);
   endfunction

   function automatic logic [63:0] goldGet(input logic [60:0] w);
      return gold.exists(w) ? gold[w] : initWord(w);
   endfunction

   // Bus responder: acknowledges each request after 0..3 idle cycles, applies
   // byte-enabled writes to its memory and logs the most recent write.
   always @(negedge clk) begin
      if (!rst_n) begin
         mem_ack = 1'b0;
         respDelay = 0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_req && !holdAck) begin
         if (respDelay > 0) begin
            respDelay--;
         end else begin
            logic [63:0] wv;
            wv = memGet(mem_addr[63:3]);
            if (mem_wen) begin
               for (int k = 0; k < 8; k++) begin
                  if (mem_be[k]) wv[k*8 +: 8] = mem_wdata[k*8 +: 8];
               end
               memArr[mem_addr[63:3]] = wv;
               memWrites++;
               lastWAddr = mem_addr;
               lastWBe   = mem_be;
               lastWData = mem_wdata;
            end else begin
               mem_rdata = wv;
               memReads++;
            end
            mem_ack = 1'b1;
            respDelay = $urandom_range(0, 3);
         end
      end
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // One DMA transaction: request held until dma_ack is seen; writes update
   // the golden memory once acknowledged.
   task automatic applyStimulus(input logic [63:0] addr, input logic wen, input logic [7:0] wdata,
                                output logic [7:0] rdata);
      logic seen;
      logic [63:0] gw;
      seen = 1'b0;
      rdata = '0;
      @(negedge clk);
      dma_req = 1'b1;
      dma_addr = addr;
      dma_wen = wen;
      dma_wdata = wdata;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (dma_ack) begin
            seen = 1'b1;
            rdata = dma_rdata;
            ackCount++;
            ackWrites = memWrites;
         end
      end
      dma_req = 1'b0;
      if (!seen) checkOutput("ack_timeout", 64'd0, 64'd1);
      if (seen && wen) begin
         gw = goldGet(addr[63:3]);
         gw[{addr[2:0], 3'b000} +: 8] = wdata;
         gold[addr[63:3]] = gw;
      end
   endtask

   task automatic pulseFlush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic waitWrites(input int target, input int bound, input string tag);
      for (int i = 0; i < bound && memWrites < target; i++) @(negedge clk);
      checkOutput(tag, 64'(memWrites), 64'(target));
   endtask

   // Directed scenarios, then a randomized mix, then a final image compare.
   initial begin
      logic [7:0]  rd;
      logic [63:0] a;
      logic [63:0] saved;
      int w0;
      int r0;
      int a0;

      rst_n = 1'b0;
      dma_req = 1'b0;
      dma_addr = '0;
      dma_wdata = '0;
      dma_wen = 1'b0;
      flush = 1'b0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst_dma_ack", 64'(dma_ack), 64'd0);
      checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
      checkOutput("rst_idle", 64'(idle), 64'd0);
      checkOutput("rst_mem_be", 64'(mem_be), 64'd0);
      checkOutput("rst_rdata", 64'(dma_rdata), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("post_rst_idle", 64'(idle), 64'd1);

      $display("[TB] T1 full-word coalescing");
      w0 = memWrites;
      a0 = ackCount;
      for (int i = 0; i < 8; i++) applyStimulus(64'h1000 + 64'(i), 1'b1, 8'(8'h11 * (i + 1)), rd);
      checkOutput("t1_acks", 64'(ackCount - a0), 64'd8);
      waitWrites(w0 + 1, 20, "t1_writes");
      checkOutput("t1_addr", lastWAddr, 64'h1000);
      checkOutput("t1_be", 64'(lastWBe), 64'hFF);
      checkOutput("t1_data", lastWData, 64'h8877665544332211);

      $display("[TB] T2 inactivity timeout");
      repeat (2) @(negedge clk);
      w0 = memWrites;
      applyStimulus(64'h2003, 1'b1, 8'hAB, rd);
      repeat (8) @(negedge clk);
      checkOutput("t2_no_early_flush", 64'(memWrites), 64'(w0));
      waitWrites(w0 + 1, 40, "t2_writes");
      checkOutput("t2_addr", lastWAddr, 64'h2000);
      checkOutput("t2_be", 64'(lastWBe), 64'h08);
      checkOutput("t2_byte3", 64'(lastWData[31:24]), 64'hAB);
      repeat (3) @(negedge clk);
      checkOutput("t2_idle", 64'(idle), 64'd1);

      $display("[TB] T3 word change forces flush");
      w0 = memWrites;
      applyStimulus(64'h3000, 1'b1, 8'h5A, rd);
      applyStimulus(64'h3008, 1'b1, 8'hC3, rd);
      checkOutput("t3_flush_before_ack", 64'(ackWrites), 64'(w0 + 1));
      checkOutput("t3_addr", lastWAddr, 64'h3000);
      checkOutput("t3_be", 64'(lastWBe), 64'h01);
      pulseFlush();
      waitWrites(w0 + 2, 20, "t3_flush_pulse");
      checkOutput("t3_addr2", lastWAddr, 64'h3008);

      $display("[TB] T4 read fetch and buffer hit");
      memArr[61'h800] = 64'h0706050403020100;
      gold[61'h800]   = 64'h0706050403020100;
      r0 = memReads;
      applyStimulus(64'h4005, 1'b0, 8'h00, rd);
      checkOutput("t4_rd05", 64'(rd), 64'h05);
      checkOutput("t4_one_fetch", 64'(memReads), 64'(r0 + 1));
      applyStimulus(64'h4006, 1'b0, 8'h00, rd);
      checkOutput("t4_rd06", 64'(rd), 64'h06);
      checkOutput("t4_no_refetch", 64'(memReads), 64'(r0 + 1));

      $display("[TB] T5 read after write to buffered word");
      w0 = memWrites;
      applyStimulus(64'h4005, 1'b1, 8'hEE, rd);
      applyStimulus(64'h4005, 1'b0, 8'h00, rd);
      checkOutput("t5_flush", 64'(ackWrites), 64'(w0 + 1));
      checkOutput("t5_be", 64'(lastWBe), 64'h20);
      checkOutput("t5_rdata", 64'(rd), 64'hEE);
      checkOutput("t5_no_refetch", 64'(memReads), 64'(r0 + 1));

      $display("[TB] T6 reset during write flush");
      saved = goldGet(61'hA00);
      w0 = memWrites;
      applyStimulus(64'h5001, 1'b1, 8'h77, rd);
      holdAck = 1'b1;
      pulseFlush();
      for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
      checkOutput("t6_req_up", 64'(mem_req), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_req_drop", 64'(mem_req), 64'd0);
      @(negedge clk);
      holdAck = 1'b0;
      rst_n = 1'b1;
      gold[61'hA00] = saved;
      repeat (40) @(negedge clk);
      checkOutput("t6_no_write", 64'(memWrites), 64'(w0));
      checkOutput("t6_idle", 64'(idle), 64'd1);

      $display("[TB] address wrap");
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h99, rd);
      applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'h00, rd);
      checkOutput("wrap_rd", 64'(rd), 64'h99);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 300; n++) begin
         logic        wen;
         logic [7:0]  wd;
         logic [63:0] gw;
         a   = 64'h8000 + 64'($urandom_range(0, 31));
         wen = 1'($urandom_range(0, 1));
         wd  = 8'($urandom);
         gw  = goldGet(a[63:3]);
         applyStimulus(a, wen, wd, rd);
         if (!wen) checkOutput("rand_rd", 64'(rd), 64'(gw[{a[2:0], 3'b000} +: 8]));
         if ($urandom_range(0, 9) == 0) pulseFlush();
         if ($urandom_range(0, 9) == 0) repeat (20) @(negedge clk);
         else repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      pulseFlush();
      for (int i = 0; i < 100 && !(idle && !mem_req); i++) @(negedge clk);
      checkOutput("drain_idle", 64'(idle), 64'd1);
      foreach (gold[w]) checkOutput("mem_image", memGet(w), gold[w]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
